// File: rtl/digit_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with a double-buffered frame.
// Each digit gets BLANK_CYCLES of all-off ghosting guard followed by DWELL_CYCLES of drive.
module digit_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [55:0] load_data,
    output logic        load_ready,
    output logic [7:0]  AN,
    output logic [6:0]  D7S,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [19:0] DWELL_LOAD  = 20'(DWELL_CYCLES - 1);
    localparam logic [19:0] BLANK_LOAD  = (BLANK_CYCLES == 0) ? 20'd0 : 20'(BLANK_CYCLES - 1);
    localparam bit          NO_BLANK    = (BLANK_CYCLES == 0);
    localparam logic [55:0] BLANK_FRAME = {8{7'h7F}};

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] count_q, count_d;
    logic [55:0] active_q, active_d;
    logic [55:0] shadow_q, shadow_d;
    logic        shadow_full_q, shadow_full_d;
    logic [7:0]  an_d;
    logic [6:0]  d7s_d;
    logic        frame_done_d;
    logic        frame_end;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;

        frame_end = (state_q == DRIVE) && (idx_q == 3'd7) && (count_q == 20'd0);

        // Load and swap are exclusive: one needs an empty shadow, the other a full one.
        if (load_valid && !shadow_full_q) begin
            shadow_d      = load_data;
            shadow_full_d = 1'b1;
        end else if (shadow_full_q && (frame_end || state_q == IDLE)) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    idx_d = 3'd0;
                    if (NO_BLANK) begin
                        state_d = DRIVE;
                        count_d = DWELL_LOAD;
                    end else begin
                        state_d = BLANK;
                        count_d = BLANK_LOAD;
                    end
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    count_d = 20'd0;
                end else if (count_q == 20'd0) begin
                    state_d = DRIVE;
                    count_d = DWELL_LOAD;
                end else begin
                    count_d = count_q - 20'd1;
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    count_d = 20'd0;
                end else if (count_q == 20'd0) begin
                    idx_d = idx_q + 3'd1;
                    if (NO_BLANK) begin
                        count_d = DWELL_LOAD;
                    end else begin
                        state_d = BLANK;
                        count_d = BLANK_LOAD;
                    end
                end else begin
                    count_d = count_q - 20'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                count_d = 20'd0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copy matches the state it sits beside.
        an_d  = 8'hFF;
        d7s_d = 7'h7F;
        if (state_d == DRIVE) begin
            an_d = ~(8'b1 << idx_d);
            for (int i = 0; i < 8; i++) begin
                if (idx_d == 3'(i)) begin
                    d7s_d = active_d[7*i +: 7];
                end
            end
        end
        frame_done_d = (state_d == DRIVE) && (idx_d == 3'd7) && (count_d == 20'd0);
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= 3'd0;
            count_q       <= 20'd0;
            // NOTE: the frame buffers are flops, not RAM, and are reset so a blank frame shows before any load.
            active_q      <= BLANK_FRAME;
            shadow_q      <= BLANK_FRAME;
            shadow_full_q <= 1'b0;
            AN            <= 8'hFF;
            D7S           <= 7'h7F;
            frame_done    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            AN            <= an_d;
            D7S           <= d7s_d;
            frame_done    <= frame_done_d;
        end
    end

    assign load_ready = !shadow_full_q;
    assign digit_idx  = idx_q;

endmodule
